// File: rtl/gcd_pack.sv
// rtl/gcd_pack.sv - shared types and defaults for the gcd_ci feeder
package gcd_pack;

   localparam int GCD_DATA_W      = 32;
   localparam int GCD_ACK_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, reads zero while empty
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gcd_feeder.sv
// rtl/gcd_feeder.sv - queues operand pairs, issues them to gcd_ci one at a time,
// and queues the results in input order
module gcd_feeder
   import gcd_pack::*;
#(
   parameter int DATA_W      = GCD_DATA_W,
   parameter int IN_DEPTH    = 8,
   parameter int OUT_DEPTH   = 8,
   parameter int ACK_TIMEOUT = GCD_ACK_TIMEOUT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_W-1:0]               in_a,
   input  logic [DATA_W-1:0]               in_b,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_W-1:0]               out_result,
   output logic                            core_clk_en,
   output logic                            core_start,
   output logic [DATA_W-1:0]               core_dataa,
   output logic [DATA_W-1:0]               core_datab,
   input  logic                            core_done,
   input  logic [DATA_W-1:0]               core_result,
   output logic                            busy,
   output logic                            err_timeout,
   output logic [$clog2(IN_DEPTH+1)-1:0]   in_count,
   output logic [$clog2(OUT_DEPTH+1)-1:0]  out_count
);

   localparam int TW = $clog2(ACK_TIMEOUT+1);

   feeder_state_t       state;
   feeder_state_t       state_nxt;
   logic [2*DATA_W-1:0] pair_head;
   logic                in_full;
   logic                in_empty;
   logic                out_full;
   logic                out_empty;
   logic                in_pop;
   logic                load;
   logic                out_push;
   logic                cnt_clr;
   logic                cnt_inc;
   logic                set_err;
   logic [TW-1:0]       wait_cnt;

   assign in_ready    = !in_full;
   assign out_valid   = !out_empty;
   assign core_clk_en = 1'b1;

   sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_ready),
      .din   ({in_a, in_b}),
      .pop   (in_pop),
      .dout  (pair_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_push),
      .din   (core_result),
      .pop   (out_valid && out_ready),
      .dout  (out_result),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         core_dataa  <= '0;
         core_datab  <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            {core_dataa, core_datab} <= pair_head;
         end
         if (cnt_clr) begin
            wait_cnt <= '0;
         end else if (cnt_inc) begin
            wait_cnt <= wait_cnt + TW'(1);
         end
         if (set_err) begin
            err_timeout <= 1'b1;
         end
      end
   end

   // Result room is reserved before issue, so the WAIT_DONE push never overflows.
   always_comb begin
      state_nxt  = state;
      in_pop     = 1'b0;
      load       = 1'b0;
      out_push   = 1'b0;
      core_start = 1'b0;
      busy       = 1'b1;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (!in_empty && !out_full) begin
               in_pop    = 1'b1;
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            core_start = 1'b1;
            cnt_clr    = 1'b1;
            state_nxt  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!core_done) begin
               state_nxt = WAIT_DONE;
            end else if (wait_cnt == TW'(ACK_TIMEOUT-1)) begin
               set_err   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (core_done) begin
               out_push  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gcd_feeder.sv
// tb/tb_gcd_feeder.sv - self-checking bench for gcd_feeder with a behavioural gcd_ci core
module tb_gcd_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        core_clk_en;
   logic        core_start;
   logic [31:0] core_dataa;
   logic [31:0] core_datab;
   logic        core_done = 1'b1;
   logic [31:0] core_result = '0;
   logic        busy;
   logic        err_timeout;
   logic [3:0]  in_count;
   logic [3:0]  out_count;

   gcd_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .core_clk_en (core_clk_en),
      .core_start  (core_start),
      .core_dataa  (core_dataa),
      .core_datab  (core_datab),
      .core_done   (core_done),
      .core_result (core_result),
      .busy        (busy),
      .err_timeout (err_timeout),
      .in_count    (in_count),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic logic [31:0] core_gcd(input logic [31:0] a, input logic [31:0] b);
      if (a == 0) return b;
      if (b == 0) return a;
      while (a != b) begin
         if (a > b) a = a - b;
         else       b = b - a;
      end
      return a;
   endfunction

   // Behavioural gcd_ci: edge-detected start, done drops, result after lat cycles.
   int          lat   = 4;
   bit          stuck = 1'b0;
   logic        prev_start = 1'b0;
   int          ccnt = 0;
   logic [31:0] ca = '0;
   logic [31:0] cb = '0;

   always @(posedge clk) begin
      prev_start <= core_start;
      if (stuck) begin
         core_done <= 1'b1;
      end else if (core_done && core_start && !prev_start) begin
         ca        <= core_dataa;
         cb        <= core_datab;
         core_done <= 1'b0;
         ccnt      <= lat;
      end else if (!core_done) begin
         if (ccnt <= 1) begin
            core_done   <= 1'b1;
            core_result <= core_gcd(ca, cb);
         end else begin
            ccnt <= ccnt - 1;
         end
      end
   end

   // Reference model: pairs awaiting issue, results awaiting delivery.
   logic [63:0] pairq[$];
   logic [31:0] expq[$];
   logic [31:0] got[$];
   int          cyc = 0;
   int          n_start = 0;
   int          last_start = -1;
   int          start_cyc = 0;
   int          acc_cyc = 0;
   bit          saw_full = 1'b0;
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [31:0] pres = '0;

   always @(negedge clk) begin
      logic [63:0] p;
      cyc++;
      if (rst) begin
         pv         = 1'b0;
         last_start = -1;
      end else begin
         if (core_start) begin
            n_start++;
            start_cyc = cyc;
            if (pairq.size() == 0) begin
               chk("issue_unexpected", 32'd1, 32'd0);
            end else begin
               p = pairq.pop_front();
               chk("issue_a", core_dataa, p[63:32]);
               chk("issue_b", core_datab, p[31:0]);
               if (!stuck) expq.push_back(ref_gcd(p[63:32], p[31:0]));
            end
            chk("issue_room", 32'(out_count < 4'd8), 32'd1);
            if (last_start >= 0) chk("start_gap", 32'((cyc - last_start) >= 3), 32'd1);
            last_start = cyc;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else                  chk("result", out_result, expq.pop_front());
            got.push_back(out_result);
         end
         if (pv && !pr) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, pres);
         end
         chk("in_ready_rule", 32'(in_ready), 32'(in_count != 4'd8));
         chk("out_valid_rule", 32'(out_valid), 32'(out_count != 4'd0));
         if (in_count == 4'd8) saw_full = 1'b1;
         pv   = out_valid;
         pr   = out_ready;
         pres = out_result;
      end
   end

   function automatic logic [31:0] got_at(input int k);
      return (k < got.size()) ? got[k] : 32'hDEAD_BEEF;
   endfunction

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      bit ok = 1'b0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (in_ready) begin
            ok      = 1'b1;
            acc_cyc = cyc;
            pairq.push_back({a, b});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = (pairq.size() == 0) && (expq.size() == 0) && !busy &&
              (in_count == 0) && (out_count == 0);
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},    32'(in_ready),    32'd1);
      chk({tag, "_out_valid"},   32'(out_valid),   32'd0);
      chk({tag, "_out_result"},  out_result,       32'd0);
      chk({tag, "_core_start"},  32'(core_start),  32'd0);
      chk({tag, "_core_dataa"},  core_dataa,       32'd0);
      chk({tag, "_core_datab"},  core_datab,       32'd0);
      chk({tag, "_core_clk_en"}, 32'(core_clk_en), 32'd1);
      chk({tag, "_busy"},        32'(busy),        32'd0);
      chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
      chk({tag, "_in_count"},    32'(in_count),    32'd0);
      chk({tag, "_out_count"},   32'(out_count),   32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      int keep;

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst0");
      rst = 1'b0;

      // Single job
      lat = 4;
      n_start = 0;
      got.delete();
      push_pair(32'd48, 32'd18);
      wait_drain();
      chk("single_starts", n_start, 32'd1);
      chk("single_latency", 32'(start_cyc - acc_cyc), 32'd2);
      chk("single_count", got.size(), 32'd1);
      chk("single_result", got_at(0), 32'd6);
      chk("single_busy", 32'(busy), 32'd0);

      // Zero operands pass through
      got.delete();
      push_pair(32'd0, 32'd7);
      push_pair(32'd9, 32'd0);
      wait_drain();
      chk("zero_count", got.size(), 32'd2);
      chk("zero_first", got_at(0), 32'd7);
      chk("zero_second", got_at(1), 32'd9);

      // Backpressure with a stalled consumer
      lat       = 6;
      out_ready = 1'b0;
      n_start   = 0;
      saw_full  = 1'b0;
      for (int i = 0; i < 12; i++) push_pair(32'd100, 32'd75);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = (n_start == 8) && !busy;
      end
      if (!ok) chk("bp_fill_timeout", 32'd0, 32'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("bp_jobs", n_start, 32'd8);
      chk("bp_out_count", 32'(out_count), 32'd8);
      chk("bp_in_count", 32'(in_count), 32'd4);
      chk("bp_saw_full", 32'(saw_full), 32'd1);
      got.delete();
      out_ready = 1'b1;
      wait_drain();
      chk("bp_drained", got.size(), 32'd12);
      for (int i = 0; i < 12; i++) chk("bp_value", got_at(i), 32'd25);

      // Start spacing with a one-cycle core
      lat = 1;
      n_start = 0;
      got.delete();
      push_pair(32'd12, 32'd8);
      push_pair(32'd35, 32'd21);
      push_pair(32'd17, 32'd5);
      push_pair(32'd64, 32'd48);
      wait_drain();
      chk("space_starts", n_start, 32'd4);
      chk("space_r0", got_at(0), 32'd4);
      chk("space_r1", got_at(1), 32'd7);
      chk("space_r2", got_at(2), 32'd1);
      chk("space_r3", got_at(3), 32'd16);

      // Timeout: core never acknowledges
      lat   = 4;
      stuck = 1'b1;
      got.delete();
      push_pair(32'd5, 32'd10);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = core_start;
      end
      if (!ok) chk("to_start_timeout", 32'd0, 32'd1);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         n++;
         ok = err_timeout;
      end
      chk("to_cycles", n, 32'd17);
      chk("to_err", 32'(err_timeout), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_out_count", 32'(out_count), 32'd0);
      @(posedge clk);
      #1;
      stuck = 1'b0;
      push_pair(32'd8, 32'd12);
      wait_drain();
      chk("to_next_count", got.size(), 32'd1);
      chk("to_next_result", got_at(0), 32'd4);
      chk("to_err_sticky", 32'(err_timeout), 32'd1);

      // Reset while the core is computing
      lat = 10;
      push_pair(32'd21, 32'd14);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = core_start;
      end
      if (!ok) chk("mr_start_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      chk("mr_busy_before", 32'(busy), 32'd1);
      keep = n_start;
      @(posedge clk);
      #1;
      rst = 1'b1;
      pairq.delete();
      expq.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_vals("midrst");
      repeat (20) @(posedge clk);
      #1;
      chk("mr_out_count", 32'(out_count), 32'd0);
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_no_issue", n_start, keep);
      chk("mr_core_idle", 32'(core_done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gcd_feeder.md
Name: gcd_feeder

Overview:
- Upstream dispatcher for the gcd_ci custom-instruction core.
- Buffers operand pairs arriving on a valid/ready stream and issues them one at a time to the core.
- Drives the core's start/dataa/datab/clk_en inputs and watches its done/result outputs.
- Queues results on a valid/ready output stream, so software or a DMA can batch GCD jobs without polling done.

Parameters:
- DATA_W, 32, operand/result width; must match the core (32).
- IN_DEPTH, 8, operand-pair FIFO depth (power of two, >=2).
- OUT_DEPTH, 8, result FIFO depth (power of two, >=2).
- ACK_TIMEOUT, 16, max cycles to wait for core_done to fall after a start pulse.

Ports:
- clk  in  1  system clock; also the core's clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand FIFO not full.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- out_valid  out  1  result FIFO not empty.
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_W  head of result FIFO.
- core_clk_en  out  1  clock enable to core.
- core_start  out  1  start to core.
- core_dataa  out  DATA_W  operand a to core.
- core_datab  out  DATA_W  operand b to core.
- core_done  in  1  core done; high when idle.
- core_result  in  DATA_W  core result; valid when core_done rises.
- busy  out  1  a job is in flight.
- err_timeout  out  1  sticky; a start pulse was never acknowledged.
- in_count  out  $clog2(IN_DEPTH+1)  operand FIFO occupancy.
- out_count  out  $clog2(OUT_DEPTH+1)  result FIFO occupancy.

Behaviour:
- Reset (synchronous; takes effect at the first clk edge with rst=1):
  - Both FIFOs emptied; state=IDLE; timeout counter=0.
  - in_ready=1, out_valid=0, out_result=0, core_start=0, core_dataa=0, core_datab=0, core_clk_en=1, busy=0, err_timeout=0, in_count=0, out_count=0.
  - Reset mid-job abandons the job: no result is pushed and the pair is lost. A late core_done rise after reset is ignored because state is IDLE.
- Input handshake:
  - A pair is accepted when in_valid && in_ready.
  - When full, in_ready=0 and the input is not accepted.
  - Simultaneous push and pop at full is not permitted, because in_ready is derived from full only.
- Output handshake:
  - The head entry pops when out_valid && out_ready.
  - Push and pop in the same cycle keep out_count unchanged.
  - out_result is stable while out_valid=1 and out_ready=0.
- State machine:
  - IDLE: if the operand FIFO is non-empty and the result FIFO is not full, pop the pair into core_dataa/core_datab and go to ISSUE. busy=0.
  - ISSUE: core_start=1 for exactly this one cycle; timeout counter cleared; go to WAIT_BUSY.
  - WAIT_BUSY: core_start=0. If core_done==0, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, set err_timeout, discard the job and go to IDLE.
  - WAIT_DONE: when core_done==1, push core_result into the result FIFO in the same cycle and go to IDLE.
- busy=1 in ISSUE, WAIT_BUSY and WAIT_DONE.
- core_dataa/core_datab hold their value from ISSUE until the next ISSUE.
- The core edge-detects start. The FSM therefore guarantees start is low for at least 2 cycles between pulses (WAIT_BUSY plus IDLE minimum).
- Result space is checked before issue, so the push in WAIT_DONE can never overflow. Only one job is ever in flight.
- err_timeout is cleared only by rst.
- Latency: in_valid accepted at cycle t. Earliest core_start is t+2, assuming the FIFO is empty and the feeder is in IDLE.
- Results leave in input order.
- A zero operand is passed through unchanged; the core handles it.

Decomposition:
- gcd_pack gains:
  - feeder_state_t enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - GCD_DATA_W=32;
  - GCD_ACK_TIMEOUT default.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports clk, rst, push, din, pop, dout, full, empty, count).
  - Instantiated twice: width 2*DATA_W for operands, DATA_W for results.
  - Show-ahead output.

Test Plan:
- Single job: push (48,18), out_ready=1, behavioural gcd_ci model -> exactly one core_start pulse with dataa=48, datab=18; out_result=6; busy returns to 0.
- Zero operands: push (0,7) then (9,0) -> results 7 then 9, in order.
- Backpressure: out_ready=0; push 12 pairs (gcd(100,75) repeated) -> in_ready=0 once in_count=8. Exactly 8 jobs run; out_count=8; no issue while the result FIFO is full. Release out_ready -> all 12 results =25 drain.
- Start spacing: 4 back-to-back pairs with a core that finishes in 1 cycle -> core_start low for >=2 cycles between pulses; 4 results.
- Timeout: hold core_done=1 permanently; push (5,10) -> err_timeout=1 after 16 WAIT_BUSY cycles; no result pushed; next pair is still issued.
- Reset mid-job: assert rst for 1 cycle in WAIT_DONE -> all outputs at reset values next cycle; a later core_done rise pushes nothing; out_count=0.
